base_spi_master: RTL and testbench

Single-byte SPI master (`base_spi`) with a shared 8-bit bidirectional data bus and an internal tri-state output stage. A host loads a transmit byte from `data` and arms the block with `en`. The block then runs one full-duplex 8-bit transfer in any of the four CPOL/CPHA modes and reports completion on `done`. The host reads the received byte back onto the same bus with `oe`. It sits between a simple host register interface and an off-chip SPI slave.

---
 rtl/base_spi_master.sv | 177 +++++++++++++++++
 tb/tb_base_spi_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_spi_master.sv
// base_spi_master: single-byte full-duplex SPI master, all four CPOL/CPHA modes, shared tri-state host bus.
// Optional macro BASE_SPI_LSB_FIRST_EN selects LSB-first shifting on TX and RX (default MSB-first).
module base_spi_master #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       we,
  input  logic       oe,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       miso,
  inout  wire  [7:0] data,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done
);

`ifdef BASE_SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_e;

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] half_q, half_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cpha_q, cpha_d;
  logic       armed_q, armed_d;
  logic       done_q, done_d;
  logic       en_q;

  logic       tick, sck_edge, edge_lead, out_bit;
  logic [7:0] tx_next, rx_next;

  assign tick    = (div_q == DIV_LAST);
  assign out_bit = LSB_FIRST ? tx_q[0] : tx_q[7];
  assign tx_next = LSB_FIRST ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};
  assign rx_next = LSB_FIRST ? {miso, rx_q[7:1]} : {rx_q[6:0], miso};

  always_comb begin
    // NOTE: every variable gets a default here first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_hold_d = rx_hold_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cpha_d    = cpha_q;
    armed_d   = armed_q;
    done_d    = 1'b0;
    sck_edge  = 1'b0;
    edge_lead = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (we) tx_d = data;
        if (armed_q && !we) begin
          state_d = S_LEAD;
          armed_d = 1'b0;
          div_d   = '0;
          half_d  = '0;
          sck_d   = cpol;
          cpha_d  = cpha;
          rx_d    = '0;
          // CPHA=0 must have the first bit on the wire before the first (sampling) leading edge.
          if (cpha) begin
            mosi_d = 1'b0;
          end else begin
            mosi_d = out_bit;
            tx_d   = tx_next;
          end
        end
      end
      S_LEAD: begin
        div_d = div_q + 8'd1;
        if (tick) begin
          div_d     = '0;
          half_d    = '0;
          state_d   = S_XFER;
          sck_edge  = 1'b1;
          edge_lead = 1'b1;
        end
      end
      S_XFER: begin
        div_d = div_q + 8'd1;
        if (tick) begin
          div_d = '0;
          if (half_q == 4'd15) begin
            state_d = S_TRAIL;
          end else begin
            // Edge number half_q+1: even numbers are leading edges.
            half_d    = half_q + 4'd1;
            sck_edge  = 1'b1;
            edge_lead = half_q[0];
          end
        end
      end
      S_TRAIL: begin
        div_d = div_q + 8'd1;
        if (tick) begin
          div_d     = '0;
          state_d   = S_IDLE;
          done_d    = 1'b1;
          rx_hold_d = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sck_edge) begin
      sck_d = ~sck_q;
      if (edge_lead ^ cpha_q) begin
        rx_d = rx_next;
      end else begin
        mosi_d = out_bit;
        tx_d   = tx_next;
      end
    end

    // A rising edge of en re-arms even while a transfer is running.
    if (en && !en_q) armed_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      half_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_hold_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cpha_q    <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_hold_q <= rx_hold_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cpha_q    <= cpha_d;
      armed_q   <= armed_d;
      done_q    <= done_d;
      en_q      <= en;
    end
  end

  assign ss   = (state_q == S_IDLE);
  assign busy = ~ss;
  assign sck  = ss ? cpol : sck_q;
  assign mosi = ss ? 1'b0 : mosi_q;
  assign done = done_q;
  assign data = (oe && !we) ? rx_hold_q : 8'bz;

endmodule

// File: tb/tb_base_spi_master.sv
// tb_base_spi_master: directed checks of base_spi_master at CLK_DIV=1 and CLK_DIV=4 (loopback),
// driving inputs and sampling outputs on the falling clock edge.
`timescale 1ns/1ps
module tb_base_spi_master;
  logic       clk = 1'b0;
  logic       rst, en, we, oe, cpol, cpha, miso_drv, sel, host_drive;
  logic [7:0] host_d;
  wire  [7:0] data1, data4;
  logic       en1, en4, miso4;
  logic       ss1, sck1, mosi1, busy1, done1;
  logic       ss4, sck4, mosi4, busy4, done4;
  logic       ss_w, sck_w, mosi_w, busy_w, done_w;
  logic [7:0] data_w;

  int checks = 0;
  int errors = 0;

  logic [7:0] r_mosi;
  int         r_rises, r_falls, r_busy, r_done, r_done_ok, r_gap, r_min_sp, r_max_sp, r_ss_bad;
  logic       r_timeout, r_aborted;

  always #5 clk = ~clk;

  assign data1  = host_drive ? host_d : 8'bz;
  assign data4  = host_drive ? host_d : 8'bz;
  assign en1    = en & ~sel;
  assign en4    = en & sel;
  assign miso4  = mosi4;
  assign ss_w   = sel ? ss4   : ss1;
  assign sck_w  = sel ? sck4  : sck1;
  assign mosi_w = sel ? mosi4 : mosi1;
  assign busy_w = sel ? busy4 : busy1;
  assign done_w = sel ? done4 : done1;
  assign data_w = sel ? data4 : data1;

  base_spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .we(we), .oe(oe), .cpol(cpol), .cpha(cpha),
    .miso(miso_drv), .data(data1), .ss(ss1), .sck(sck1), .mosi(mosi1), .busy(busy1), .done(done1)
  );

  base_spi_master #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .we(we), .oe(oe), .cpol(cpol), .cpha(cpha),
    .miso(miso4), .data(data4), .ss(ss4), .sck(sck4), .mosi(mosi4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte as it appears on the wire, first bit in position 7.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef BASE_SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  // Loads tx, raises en and follows one transfer while acting as the slave for dut1.
  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slv, input int peek_at,
                         input logic [7:0] peek_exp, input int poke_at, input int rearm,
                         input int abort_at);
    logic [7:0] s;
    int         sidx, edges, idle_cnt, last_t, budget;
    logic       prev_sck, prev_busy, seen_busy, poking, leading;
    s = wire_order(slv);
    r_mosi = '0; r_rises = 0; r_falls = 0; r_busy = 0; r_done = 0; r_done_ok = 0;
    r_gap = -1; r_min_sp = 1000; r_max_sp = 0; r_ss_bad = 0; r_aborted = 1'b0;
    budget = 40 * (sel ? 4 : 1) + 60;
    @(negedge clk);
    en = 1'b0; host_d = tx; host_drive = 1'b1; we = 1'b1;
    @(negedge clk);
    we = 1'b0; host_drive = 1'b0; en = 1'b1;
    sidx = 0;
    if (!cpha) begin
      miso_drv = s[7];
      sidx = 1;
    end
    prev_sck = sck_w; prev_busy = busy_w; seen_busy = 1'b0;
    idle_cnt = 0; edges = 0; poking = 1'b0; last_t = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (poking) begin
        we = 1'b0; host_drive = 1'b0; poking = 1'b0;
      end
      if (ss_w !== ~busy_w) r_ss_bad++;
      if (busy_w) begin
        if (!prev_busy && seen_busy) r_gap = idle_cnt;
        seen_busy = 1'b1; idle_cnt = 0; r_busy++;
      end else begin
        idle_cnt++;
      end
      if (done_w) begin
        r_done++;
        if (prev_busy && !busy_w) r_done_ok++;
      end
      if (sck_w !== prev_sck) begin
        leading = (prev_sck == cpol);
        if (sck_w) r_rises++; else r_falls++;
        if (edges > 0) begin
          if (cyc - last_t < r_min_sp) r_min_sp = cyc - last_t;
          if (cyc - last_t > r_max_sp) r_max_sp = cyc - last_t;
        end
        last_t = cyc;
        edges++;
        if (leading ^ cpha) r_mosi = {r_mosi[6:0], mosi_w};
        else if (sidx < 8) begin
          miso_drv = s[7-sidx];
          sidx++;
        end
        if (edges == peek_at) begin
          oe = 1'b1; #1;
          check("peek_rx_during_busy", data_w, peek_exp);
          oe = 1'b0;
        end
        if (edges == poke_at) begin
          host_d = 8'h11; host_drive = 1'b1; we = 1'b1; poking = 1'b1;
        end
        if (rearm != 0 && edges == 6) en = 1'b0;
        if (rearm != 0 && edges == 8) en = 1'b1;
        if (edges == abort_at) begin
          rst = 1'b0; #1;
          check("abort_ss", ss_w, 1);
          check("abort_busy", busy_w, 0);
          check("abort_mosi", mosi_w, 0);
          r_aborted = 1'b1;
          break;
        end
      end
      prev_sck = sck_w; prev_busy = busy_w;
      if (seen_busy && idle_cnt >= 3) break;
    end
    r_timeout = !(seen_busy && idle_cnt >= 3) && !r_aborted;
  endtask

  task automatic xfer_checks(input string p, input logic [7:0] tx, input int busy_exp, input int sp);
    check({p, "_budget"}, r_timeout, 0);
    check({p, "_mosi"}, r_mosi, wire_order(tx));
    check({p, "_rises"}, r_rises, 8);
    check({p, "_falls"}, r_falls, 8);
    check({p, "_busy_cycles"}, r_busy, busy_exp);
    check({p, "_done_pulses"}, r_done, 1);
    check({p, "_done_after_busy"}, r_done_ok, 1);
    check({p, "_half_min"}, r_min_sp, sp);
    check({p, "_half_max"}, r_max_sp, sp);
    check({p, "_ss_vs_busy"}, r_ss_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b0; en = 1'b0; we = 1'b0; oe = 1'b0; cpol = 1'b0; cpha = 1'b0;
    miso_drv = 1'b0; sel = 1'b0; host_drive = 1'b0; host_d = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_ss", ss_w, 1);
    check("rst_sck", sck_w, 0);
    check("rst_mosi", mosi_w, 0);
    check("rst_busy", busy_w, 0);
    check("rst_done", done_w, 0);
    host_d = 8'hA5; host_drive = 1'b1; #1;
    check("rst_bus_released", data_w, 8'hA5);
    host_drive = 1'b0; oe = 1'b1; #1;
    check("rst_rx_cleared", data_w, 8'h00);
    oe = 1'b0; cpol = 1'b1; #1;
    check("rst_sck_live_cpol", sck_w, 1);
    cpol = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Mode 1, CLK_DIV=1: TX 0xAA, slave holds miso high.
    cpol = 1'b0; cpha = 1'b1; miso_drv = 1'b1;
    do_xfer(8'hAA, 8'hFF, 0, 8'h00, 0, 0, 0);
    xfer_checks("m1", 8'hAA, 18, 1);
    oe = 1'b1; #1;
    check("m1_rx", data_w, 8'hFF);
    host_d = 8'h5C; host_drive = 1'b1; we = 1'b1; #1;
    check("bus_we_priority", data_w, 8'h5C);
    we = 1'b0; oe = 1'b0; host_d = 8'h3A; #1;
    check("bus_oe_low_released", data_w, 8'h3A);
    host_drive = 1'b0;

    // en stays high: no second transfer may start.
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_w) cnt++;
    end
    check("single_shot_hold_en", cnt, 0);

    // Mode 0: peek mid-transfer, attempted TX overwrite during busy.
    cpha = 1'b0;
    do_xfer(8'h3C, 8'hC5, 4, 8'hFF, 2, 0, 0);
    xfer_checks("m0", 8'h3C, 18, 1);
    oe = 1'b1; #1;
    check("m0_rx", data_w, 8'hC5);
    oe = 1'b0;
    check("m0_sck_idle", sck_w, 0);

    // Mode 2.
    cpol = 1'b1; cpha = 1'b0;
    do_xfer(8'h96, 8'h69, 0, 8'h00, 0, 0, 0);
    xfer_checks("m2", 8'h96, 18, 1);
    oe = 1'b1; #1;
    check("m2_rx", data_w, 8'h69);
    oe = 1'b0;
    check("m2_sck_idle", sck_w, 1);

    // Abort after the 4th SCK edge.
    cpol = 1'b0; cpha = 1'b1; miso_drv = 1'b1;
    do_xfer(8'hAA, 8'hFF, 0, 8'h00, 0, 0, 4);
    check("abort_reached", r_aborted, 1);
    en = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_w) cnt++;
    end
    check("abort_no_done", cnt, 0);
    oe = 1'b1; #1;
    check("abort_rx_cleared", data_w, 8'h00);
    oe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy_w) cnt++;
    end
    check("abort_stays_idle", cnt, 0);

    // Re-arm during busy: second transfer starts one cycle after IDLE.
    do_xfer(8'h81, 8'h00, 0, 8'h00, 0, 1, 0);
    check("rearm_budget", r_timeout, 0);
    check("rearm_busy_cycles", r_busy, 36);
    check("rearm_done_pulses", r_done, 2);
    check("rearm_done_after_busy", r_done_ok, 2);
    check("rearm_idle_gap", r_gap, 1);

    // Mode 3, CLK_DIV=4, loopback mosi->miso.
    en = 1'b0;
    @(negedge clk);
    sel = 1'b1; cpol = 1'b1; cpha = 1'b1;
    @(negedge clk);
    check("m3_sck_idle_high", sck_w, 1);
    do_xfer(8'h5A, 8'h00, 0, 8'h00, 0, 0, 0);
    xfer_checks("m3", 8'h5A, 72, 4);
    oe = 1'b1; #1;
    check("m3_rx_loopback", data_w, 8'h5A);
    oe = 1'b0; en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
